// File: rtl/i2s_pkg.sv
// i2s_pkg: shared defaults, channel encoding and serializer state type for the I2S master
package i2s_pkg;
    localparam int   DATA_W_DEF   = 12;
    localparam int   HALF_DIV_DEF = 32;
    localparam logic LEFT         = 1'b0;
    localparam logic RIGHT        = 1'b1;
    typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/i2s_master_bit_clk_gen.sv
// bit_clk_gen: divides clk into a 50% duty bclk and flags the cycle on which bclk falls
module bit_clk_gen
    import i2s_pkg::*;
#(
    parameter int HALF_DIV = HALF_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    output logic bclk,
    output logic fall_en
);
    localparam int CW = $clog2(HALF_DIV);
    logic [CW-1:0] cnt;
    logic          wrap;
    assign wrap    = cnt == CW'(HALF_DIV - 1);
    assign fall_en = wrap && bclk;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            bclk <= 1'b0;
        end else begin
            cnt  <= wrap ? '0 : cnt + 1'b1;
            bclk <= bclk ^ wrap;
        end
    end
endmodule

// File: rtl/i2s_master.sv
// i2s_master: standard I2S transmitter; serializes left/right samples MSB-first behind a divided bit clock
module i2s_master
    import i2s_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int HALF_DIV = HALF_DIV_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] right_audio,
    input  logic [DATA_W-1:0] left_audio,
    output logic              bclk,
    output logic              lrclk,
    output logic              sdata,
    output logic              right_n_left
);
    localparam int BW = $clog2(DATA_W);
    logic              fall_en, ch;
    state_t            state, state_n;
    logic [BW-1:0]     bit_cnt, bit_cnt_n;
    logic [DATA_W-1:0] shift, shift_n;
    logic              lrclk_n, sdata_n, rnl_n;
    bit_clk_gen #(.HALF_DIV(HALF_DIV)) u_bclk (
        .clk     (clk),
        .rst     (rst),
        .bclk    (bclk),
        .fall_en (fall_en)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shift        <= '0;
            lrclk        <= LEFT;
            sdata        <= 1'b0;
            right_n_left <= LEFT;
        end else begin
            state        <= state_n;
            bit_cnt      <= bit_cnt_n;
            shift        <= shift_n;
            lrclk        <= lrclk_n;
            sdata        <= sdata_n;
            right_n_left <= rnl_n;
        end
    end
    // At slot start the old word's LSB is still in the top bit, so sdata always takes shift's MSB
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        lrclk_n   = lrclk;
        sdata_n   = sdata;
        rnl_n     = right_n_left;
        ch        = (state == IDLE) ? LEFT : ~lrclk;
        if (fall_en) begin
            if (!enable) begin
                state_n   = IDLE;
                bit_cnt_n = '0;
                shift_n   = '0;
                lrclk_n   = LEFT;
                sdata_n   = 1'b0;
                rnl_n     = LEFT;
            end else begin
                state_n   = RUN;
                sdata_n   = shift[DATA_W-1];
                bit_cnt_n = (bit_cnt == BW'(DATA_W - 1)) ? '0 : bit_cnt + 1'b1;
                if (bit_cnt == '0) begin
                    lrclk_n = ch;
                    shift_n = (ch == RIGHT) ? right_audio : left_audio;
                end else begin
                    shift_n = shift << 1;
                    rnl_n   = (bit_cnt == BW'(1)) ? lrclk : right_n_left;
                end
            end
        end
    end
endmodule

// File: tb/tb_i2s_master.sv
// tb_i2s_master: table vectors, hand sequences and randomized traffic against a slot-arithmetic model
module tb_i2s_master;
    localparam int DW = 12;
    localparam int HD = 32;
    logic clk = 1'b0, rst = 1'b0, enable = 1'b0;
    logic [DW-1:0] right_audio = '0, left_audio = '0;
    logic bclk, lrclk, sdata, right_n_left;
    int ntests = 0, nfail = 0, nfall = 0;
    bit armed = 0;
    always #5 clk = ~clk;
    i2s_master #(.DATA_W(DW), .HALF_DIV(HD)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .right_audio  (right_audio),
        .left_audio   (left_audio),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .right_n_left (right_n_left)
    );
    task automatic chk(input string name, input int act, input int exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask
    // Reference: position in the stream since enable decides channel, slot and bit index
    int k = 0, bcnt = 0;
    logic pb = 1'b0, e_lr = 1'b0, e_sd = 1'b0, e_rnl = 1'b0;
    logic [DW-1:0] cur_w = '0;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            armed = 1;
            k = 0; bcnt = 0; pb = 1'b0; cur_w = '0;
            e_lr = 1'b0; e_sd = 1'b0; e_rnl = 1'b0;
            chk("reset_outs", {bclk, lrclk, sdata, right_n_left}, 0);
        end else if (armed) begin
            bcnt++;
            if (bclk !== pb) begin
                chk("bclk_half", bcnt, HD);
                bcnt = 0;
            end
            if (pb && !bclk) begin
                if (!enable) begin
                    k = 0; cur_w = '0;
                    e_lr = 1'b0; e_sd = 1'b0; e_rnl = 1'b0;
                end else begin
                    int pos, slot;
                    logic chn;
                    pos  = k % DW;
                    slot = k / DW;
                    chn  = slot[0];
                    e_lr = chn;
                    if (pos == 0) begin
                        e_sd  = cur_w[0];
                        cur_w = chn ? right_audio : left_audio;
                    end else begin
                        e_sd  = cur_w[DW-pos];
                        e_rnl = chn;
                    end
                    k++;
                end
                nfall++;
            end
            pb = bclk;
            chk("lrclk", lrclk, e_lr);
            chk("sdata", sdata, e_sd);
            chk("right_n_left", right_n_left, e_rnl);
        end
    end
    task automatic wait_fall();
        int n0 = nfall;
        int t = 0;
        while (nfall == n0 && t < 4 * HD) begin
            @(posedge clk);
            #2;
            t++;
        end
        chk("fall_seen", int'(nfall != n0), 1);
    endtask
    typedef struct {
        int   n;
        logic sd, lr, rnl;
    } vec_t;
    vec_t vecs[10];
    int base;
    initial begin
        vecs[0] = '{1, 0, 0, 0};
        vecs[1] = '{2, 1, 0, 0};
        vecs[2] = '{3, 0, 0, 0};
        vecs[3] = '{12, 0, 0, 0};
        vecs[4] = '{13, 1, 1, 0};
        vecs[5] = '{14, 1, 1, 1};
        vecs[6] = '{24, 1, 1, 1};
        vecs[7] = '{25, 1, 0, 1};
        vecs[8] = '{26, 1, 0, 0};
        vecs[9] = '{27, 0, 0, 0};
        #12 rst = 1'b1;
        #1 chk("async_reset", {bclk, lrclk, sdata, right_n_left}, 0);
        #11 rst = 1'b0;
        // Boundary word 0x801 on the left, all ones on the right
        left_audio  = 12'h801;
        right_audio = 12'hFFF;
        @(negedge clk);
        base   = nfall;
        enable = 1'b1;
        foreach (vecs[i]) begin
            while (nfall - base < vecs[i].n) wait_fall();
            chk($sformatf("vec%0d_sdata", vecs[i].n), sdata, vecs[i].sd);
            chk($sformatf("vec%0d_lrclk", vecs[i].n), lrclk, vecs[i].lr);
            chk($sformatf("vec%0d_rnl", vecs[i].n), right_n_left, vecs[i].rnl);
        end
        // Drop enable in the middle of a right slot, then restart
        while (nfall - base < 40) wait_fall();
        chk("pre_drop_lrclk", lrclk, 1);
        @(negedge clk);
        enable = 1'b0;
        wait_fall();
        chk("drop_lrclk", lrclk, 0);
        chk("drop_sdata", sdata, 0);
        chk("drop_rnl", right_n_left, 0);
        wait_fall();
        wait_fall();
        chk("idle_sdata", sdata, 0);
        @(negedge clk);
        left_audio = 12'hA5A;
        enable     = 1'b1;
        wait_fall();
        chk("restart_lrclk", lrclk, 0);
        chk("restart_sdata", sdata, 0);
        wait_fall();
        chk("restart_msb", sdata, 1);
        wait_fall();
        chk("restart_bit10", sdata, 0);
        // Randomized traffic with sparse enable toggles and one mid-frame reset
        for (int i = 0; i < 30000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 199) == 0) left_audio = DW'($urandom);
            if ($urandom_range(0, 199) == 0) right_audio = DW'($urandom);
            if ($urandom_range(0, 4999) == 0) enable = ~enable;
            if (i == 15000) begin
                #2 rst = 1'b1;
                #1 chk("mid_reset", {bclk, lrclk, sdata, right_n_left}, 0);
                #11 rst = 1'b0;
                enable = 1'b1;
            end
        end
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
